// File: rtl/sprite_pkg.sv
// sprite_pkg: shared screen constants and pixel/colour types for the sprite compositor
package sprite_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  typedef logic [9:0] coord_t;
  typedef logic [23:0] rgb_t;
  typedef logic [3:0] pal_idx_t;
endpackage

// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: ROM and palette lookup bus between the compositor and its memories
interface sprite_compositor_if;
  import sprite_pkg::*;
  logic [15:0] Spr_addr;
  logic [1:0] Spr_img;
  pal_idx_t Spr_data;
  logic [18:0] Bg_addr;
  pal_idx_t Bg_data;
  pal_idx_t Pal_idx;
  rgb_t Pal_rgb;
  modport master (output Spr_addr, Spr_img, Bg_addr, Pal_idx, input Spr_data, Bg_data, Pal_rgb);
  modport slave (input Spr_addr, Spr_img, Bg_addr, Pal_idx, output Spr_data, Bg_data, Pal_rgb);
endinterface

// File: rtl/sprite_hit_arbiter.sv
// sprite_hit_arbiter: per-sprite rectangle test and lowest-index priority pick with ROM address
module sprite_hit_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = 4,
  parameter int SPR_W = 70,
  parameter int SPR_H = 50,
  localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
  input coord_t drawX,
  input coord_t drawY,
  input logic [NUM_SPR*10-1:0] sprX,
  input logic [NUM_SPR*10-1:0] sprY,
  input logic [NUM_SPR-1:0] sprEn,
  output logic hit,
  output logic [IW-1:0] winner,
  output logic [15:0] addr
);
  logic [10:0] dx, dy;
  // scan from lowest priority upward so the lowest-index hit is the last one written
  always_comb begin
    hit = 1'b0;
    winner = '0;
    addr = '0;
    dx = '0;
    dy = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      dx = {1'b0, drawX} - {1'b0, sprX[i*10 +: 10]};
      dy = {1'b0, drawY} - {1'b0, sprY[i*10 +: 10]};
      if (sprEn[i] && !dx[10] && !dy[10] && dx < 11'(SPR_W) && dy < 11'(SPR_H)) begin
        hit = 1'b1;
        winner = IW'(i);
        addr = 16'(dy) * 16'(SPR_W) + 16'(dx);
      end
    end
  end
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: 2-cycle sprite/bullet/background pixel compositor; optional SPRITE_HIT_FLASH_EN adds hit-flash inversion
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPR = 4,
  parameter int NUM_BUL = 2,
  parameter int SPR_W = 70,
  parameter int SPR_H = 50,
  parameter int BUL_R = 4,
  parameter pal_idx_t TRANSP_IDX = 4'h0,
  parameter rgb_t BUL_RGB = 24'hFF00FF,
  parameter int FLASH_FRAMES = 32
) (
  input logic Clk,
  input logic Reset,
  input coord_t DrawX,
  input coord_t DrawY,
  input logic Pix_valid,
  input logic Frame_start,
  input logic [NUM_SPR*10-1:0] SprX,
  input logic [NUM_SPR*10-1:0] SprY,
  input logic [NUM_SPR-1:0] Spr_en,
  input logic [NUM_SPR*2-1:0] Spr_sel,
  input logic [NUM_BUL*10-1:0] BulX,
  input logic [NUM_BUL*10-1:0] BulY,
  input logic [NUM_BUL-1:0] Bul_en,
  sprite_compositor_if.master rom,
  input logic [NUM_SPR-1:0] Hit_flash,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic Rgb_valid
);
  localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam logic signed [21:0] BR2 = 22'(BUL_R * BUL_R);
  logic [NUM_SPR*10-1:0] sprXS, sprYS;
  logic [NUM_SPR-1:0] sprEnS;
  logic [NUM_SPR*2-1:0] sprSelS;
  logic [NUM_BUL*10-1:0] bulXS, bulYS;
  logic [NUM_BUL-1:0] bulEnS;
  logic sprHit, bulHit, sprHitD, bulHitD, validD;
  logic [IW-1:0] winner;
  logic [15:0] sprAddr;
  logic signed [10:0] bdx, bdy;
  logic signed [21:0] bx, by;
  logic opaque, flashOn;
  rgb_t colour;
  // shadow copy of object positions, refreshed only at frame start so nothing tears mid-frame
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sprXS <= '0;
      sprYS <= '0;
      sprEnS <= '0;
      sprSelS <= '0;
      bulXS <= '0;
      bulYS <= '0;
      bulEnS <= '0;
    end else if (Frame_start) begin
      sprXS <= SprX;
      sprYS <= SprY;
      sprEnS <= Spr_en;
      sprSelS <= Spr_sel;
      bulXS <= BulX;
      bulYS <= BulY;
      bulEnS <= Bul_en;
    end
  end
  sprite_hit_arbiter #(.NUM_SPR(NUM_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H)) u_arb (
    .drawX(DrawX),
    .drawY(DrawY),
    .sprX(sprXS),
    .sprY(sprYS),
    .sprEn(sprEnS),
    .hit(sprHit),
    .winner(winner),
    .addr(sprAddr)
  );
  // round bullets: squared distance from each enabled centre against the squared radius
  always_comb begin
    bulHit = 1'b0;
    bdx = '0;
    bdy = '0;
    bx = '0;
    by = '0;
    for (int j = 0; j < NUM_BUL; j++) begin
      bdx = $signed({1'b0, DrawX}) - $signed({1'b0, bulXS[j*10 +: 10]});
      bdy = $signed({1'b0, DrawY}) - $signed({1'b0, bulYS[j*10 +: 10]});
      bx = 22'(bdx);
      by = 22'(bdy);
      bulHit = bulHit | (bulEnS[j] && (bx * bx + by * by <= BR2));
    end
  end
  // stage 0 register: ROM addresses plus hit flags travelling alongside the pixel
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rom.Spr_addr <= '0;
      rom.Spr_img <= '0;
      rom.Bg_addr <= '0;
      sprHitD <= 1'b0;
      bulHitD <= 1'b0;
      validD <= 1'b0;
    end else begin
      rom.Spr_addr <= sprHit ? sprAddr : '0;
      rom.Spr_img <= sprHit ? sprSelS[winner*2 +: 2] : '0;
      rom.Bg_addr <= 19'(DrawY) * 19'(H_RES) + 19'(DrawX);
      sprHitD <= sprHit;
      bulHitD <= bulHit;
      validD <= Pix_valid;
    end
  end
`ifdef SPRITE_HIT_FLASH_EN
  logic [5:0] flashCnt [NUM_SPR];
  logic [IW-1:0] winnerD;
  // per-sprite flash timers: reload on hit, count frames down to zero
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      winnerD <= '0;
      for (int i = 0; i < NUM_SPR; i++) flashCnt[i] <= '0;
    end else begin
      winnerD <= winner;
      for (int i = 0; i < NUM_SPR; i++)
        flashCnt[i] <= Hit_flash[i] ? 6'(FLASH_FRAMES) :
                       (Frame_start && flashCnt[i] != '0) ? flashCnt[i] - 6'd1 : flashCnt[i];
    end
  end
  assign flashOn = flashCnt[winnerD] != '0 && flashCnt[winnerD][2];
`else
  logic unusedFlash;
  assign unusedFlash = ^{Hit_flash, 6'(FLASH_FRAMES)};
  assign flashOn = 1'b0;
`endif
  // stage 1: winning opaque sprite, else bullet, else background
  always_comb begin
    opaque = sprHitD && rom.Spr_data != TRANSP_IDX;
    rom.Pal_idx = validD ? (opaque ? rom.Spr_data : rom.Bg_data) : '0;
    colour = opaque ? (flashOn ? ~rom.Pal_rgb : rom.Pal_rgb) : bulHitD ? BUL_RGB : rom.Pal_rgb;
  end
  // stage 2: registered DAC outputs, blanked outside the visible region
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      {Red, Green, Blue} <= '0;
      Rgb_valid <= 1'b0;
    end else begin
      {Red, Green, Blue} <= validD ? colour : '0;
      Rgb_valid <= validD;
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed checks of latency, priority, bounds, bullets, latching and reset
module tb_sprite_compositor;
  import sprite_pkg::*;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset, Pix_valid, Frame_start;
  coord_t DrawX, DrawY;
  logic [39:0] SprX, SprY;
  logic [3:0] Spr_en, Hit_flash;
  logic [7:0] Spr_sel;
  logic [19:0] BulX, BulY;
  logic [1:0] Bul_en;
  logic [7:0] Red, Green, Blue;
  logic Rgb_valid;
  int nCmp = 0, nErr = 0;
  logic [15:0] gAddr;
  logic [1:0] gImg;
  pal_idx_t gPal;
  logic [18:0] gBg;
  rgb_t gRgb;
  logic gVld;
  sprite_compositor_if rom();
  function automatic rgb_t palf(input pal_idx_t i);
    return i == 4'd0 ? 24'h000000 : i == 4'd3 ? 24'h00FF00 : i == 4'd5 ? 24'h123456 :
           i == 4'd7 ? 24'hABCDEF : 24'h0F0F0F;
  endfunction
  assign rom.Pal_rgb = palf(rom.Pal_idx);
  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .Pix_valid(Pix_valid),
    .Frame_start(Frame_start), .SprX(SprX), .SprY(SprY), .Spr_en(Spr_en), .Spr_sel(Spr_sel),
    .BulX(BulX), .BulY(BulY), .Bul_en(Bul_en), .rom(rom), .Hit_flash(Hit_flash),
    .Red(Red), .Green(Green), .Blue(Blue), .Rgb_valid(Rgb_valid)
  );
  task automatic pixel(input int x, input int y, input logic v, input pal_idx_t sd, input pal_idx_t bd);
    @(posedge Clk); #1;
    DrawX = 10'(x); DrawY = 10'(y); Pix_valid = v; rom.Spr_data = sd; rom.Bg_data = bd;
    @(posedge Clk); #1;
    gAddr = rom.Spr_addr; gImg = rom.Spr_img; gPal = rom.Pal_idx; gBg = rom.Bg_addr;
    @(posedge Clk); #1;
    gRgb = {Red, Green, Blue}; gVld = Rgb_valid;
  endtask
  task automatic frame();
    @(posedge Clk); #1 Frame_start = 1'b1;
    @(posedge Clk); #1 Frame_start = 1'b0;
  endtask
  task automatic set_spr(input int i, input int x, input int y, input logic en, input logic [1:0] sel);
    SprX[i*10 +: 10] = 10'(x); SprY[i*10 +: 10] = 10'(y); Spr_en[i] = en; Spr_sel[i*2 +: 2] = sel;
  endtask
  task automatic test_reset();
    Reset = 1'b1; Pix_valid = 0; Frame_start = 0; DrawX = 0; DrawY = 0;
    SprX = '0; SprY = '0; Spr_en = '0; Spr_sel = '0; BulX = '0; BulY = '0; Bul_en = '0; Hit_flash = '0;
    rom.Spr_data = 0; rom.Bg_data = 0;
    #1 Reset = 1'b0;
    #1;
    nCmp++; if ({Red, Green, Blue} !== 24'h0) begin nErr++; $display("FAIL reset_rgb got %h want %h", {Red, Green, Blue}, 24'h0); end
    nCmp++; if (Rgb_valid !== 1'b0) begin nErr++; $display("FAIL reset_valid got %b want 0", Rgb_valid); end
    nCmp++; if (rom.Spr_addr !== 16'd0) begin nErr++; $display("FAIL reset_spr_addr got %0d want 0", rom.Spr_addr); end
    nCmp++; if (rom.Bg_addr !== 19'd0) begin nErr++; $display("FAIL reset_bg_addr got %0d want 0", rom.Bg_addr); end
    nCmp++; if (rom.Pal_idx !== 4'd0) begin nErr++; $display("FAIL reset_pal_idx got %0d want 0", rom.Pal_idx); end
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
  endtask
  task automatic test_sprite();
    set_spr(0, 100, 100, 1'b1, 2'd3);
    pixel(100, 100, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'h123456) begin nErr++; $display("FAIL prelatch_rgb got %h want %h", gRgb, 24'h123456); end
    frame();
    pixel(100, 100, 1, 4'd3, 4'd5);
    nCmp++; if (gAddr !== 16'd0) begin nErr++; $display("FAIL spr_addr0 got %0d want 0", gAddr); end
    nCmp++; if (gImg !== 2'd3) begin nErr++; $display("FAIL spr_img0 got %0d want 3", gImg); end
    nCmp++; if (gBg !== 19'd64100) begin nErr++; $display("FAIL bg_addr got %0d want 64100", gBg); end
    nCmp++; if (gRgb !== 24'h00FF00) begin nErr++; $display("FAIL spr_rgb got %h want %h", gRgb, 24'h00FF00); end
    nCmp++; if (gVld !== 1'b1) begin nErr++; $display("FAIL spr_valid got %b want 1", gVld); end
    pixel(169, 149, 1, 4'd3, 4'd5);
    nCmp++; if (gAddr !== 16'd3499) begin nErr++; $display("FAIL spr_corner_addr got %0d want 3499", gAddr); end
    nCmp++; if (gRgb !== 24'h00FF00) begin nErr++; $display("FAIL spr_corner_rgb got %h want %h", gRgb, 24'h00FF00); end
    pixel(170, 149, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'h123456) begin nErr++; $display("FAIL spr_xbound_rgb got %h want %h", gRgb, 24'h123456); end
    pixel(169, 150, 1, 4'd3, 4'd5);
    nCmp++; if (gImg !== 2'd0) begin nErr++; $display("FAIL spr_ybound_img got %0d want 0", gImg); end
  endtask
  task automatic test_priority();
    set_spr(0, 200, 200, 1'b1, 2'd2);
    set_spr(1, 200, 200, 1'b1, 2'd1);
    set_spr(2, 600, 10, 1'b1, 2'd1);
    set_spr(3, 1000, 10, 1'b1, 2'd3);
    frame();
    pixel(210, 205, 1, 4'd3, 4'd5);
    nCmp++; if (gAddr !== 16'd360) begin nErr++; $display("FAIL prio_addr got %0d want 360", gAddr); end
    nCmp++; if (gImg !== 2'd2) begin nErr++; $display("FAIL prio_img got %0d want 2", gImg); end
    pixel(270, 200, 1, 4'd3, 4'd5);
    nCmp++; if (gAddr !== 16'd0) begin nErr++; $display("FAIL excl_addr got %0d want 0", gAddr); end
    nCmp++; if (gRgb !== 24'h123456) begin nErr++; $display("FAIL excl_rgb got %h want %h", gRgb, 24'h123456); end
    pixel(639, 10, 1, 4'd3, 4'd5);
    nCmp++; if (gAddr !== 16'd39) begin nErr++; $display("FAIL clip_addr got %0d want 39", gAddr); end
    nCmp++; if (gImg !== 2'd1) begin nErr++; $display("FAIL clip_img got %0d want 1", gImg); end
    pixel(5, 10, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'h123456) begin nErr++; $display("FAIL wrap_rgb got %h want %h", gRgb, 24'h123456); end
  endtask
  task automatic test_bullet();
    BulX = {10'd50, 10'd300}; BulY = {10'd50, 10'd300}; Bul_en = 2'b01;
    frame();
    pixel(304, 300, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'hFF00FF) begin nErr++; $display("FAIL bul_edge got %h want %h", gRgb, 24'hFF00FF); end
    pixel(296, 300, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'hFF00FF) begin nErr++; $display("FAIL bul_left got %h want %h", gRgb, 24'hFF00FF); end
    pixel(303, 303, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'h123456) begin nErr++; $display("FAIL bul_diag got %h want %h", gRgb, 24'h123456); end
    pixel(300, 305, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'h123456) begin nErr++; $display("FAIL bul_below got %h want %h", gRgb, 24'h123456); end
    pixel(50, 50, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'h123456) begin nErr++; $display("FAIL bul_disabled got %h want %h", gRgb, 24'h123456); end
  endtask
  task automatic test_overlap();
    set_spr(3, 290, 290, 1'b1, 2'd0);
    frame();
    pixel(300, 300, 1, 4'd7, 4'd5);
    nCmp++; if (gPal !== 4'd7) begin nErr++; $display("FAIL ovl_pal got %0d want 7", gPal); end
    nCmp++; if (gRgb !== 24'hABCDEF) begin nErr++; $display("FAIL ovl_opaque got %h want %h", gRgb, 24'hABCDEF); end
    pixel(300, 300, 1, 4'd0, 4'd5);
    nCmp++; if (gRgb !== 24'hFF00FF) begin nErr++; $display("FAIL ovl_transp got %h want %h", gRgb, 24'hFF00FF); end
    pixel(300, 300, 0, 4'd7, 4'd5);
    nCmp++; if (gRgb !== 24'h0) begin nErr++; $display("FAIL blank_rgb got %h want 0", gRgb); end
    nCmp++; if (gVld !== 1'b0) begin nErr++; $display("FAIL blank_valid got %b want 0", gVld); end
  endtask
  task automatic test_latch();
    set_spr(0, 400, 200, 1'b1, 2'd2);
    pixel(210, 205, 1, 4'd3, 4'd5);
    nCmp++; if (gAddr !== 16'd360) begin nErr++; $display("FAIL latch_hold got %0d want 360", gAddr); end
    frame();
    pixel(210, 205, 1, 4'd3, 4'd5);
    nCmp++; if (gImg !== 2'd1) begin nErr++; $display("FAIL latch_old_img got %0d want 1", gImg); end
    set_spr(1, 200, 200, 1'b0, 2'd1);
    frame();
    pixel(210, 205, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'h123456) begin nErr++; $display("FAIL latch_old_pos got %h want %h", gRgb, 24'h123456); end
    pixel(410, 205, 1, 4'd3, 4'd5);
    nCmp++; if (gAddr !== 16'd360) begin nErr++; $display("FAIL latch_new_addr got %0d want 360", gAddr); end
    nCmp++; if (gRgb !== 24'h00FF00) begin nErr++; $display("FAIL latch_new_rgb got %h want %h", gRgb, 24'h00FF00); end
  endtask
  task automatic test_async_reset();
    @(posedge Clk); #3 Reset = 1'b0;
    #1;
    nCmp++; if ({Red, Green, Blue} !== 24'h0) begin nErr++; $display("FAIL areset_rgb got %h want 0", {Red, Green, Blue}); end
    nCmp++; if (Rgb_valid !== 1'b0) begin nErr++; $display("FAIL areset_valid got %b want 0", Rgb_valid); end
    @(posedge Clk); #1 Reset = 1'b1;
    pixel(410, 205, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'h123456) begin nErr++; $display("FAIL areset_shadow got %h want %h", gRgb, 24'h123456); end
  endtask
`ifdef SPRITE_HIT_FLASH_EN
  task automatic test_flash();
    frame();
    @(posedge Clk); #1 Hit_flash = 4'b0001;
    @(posedge Clk); #1 Hit_flash = 4'b0000;
    pixel(410, 205, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'h00FF00) begin nErr++; $display("FAIL flash_cnt32 got %h want %h", gRgb, 24'h00FF00); end
    frame();
    pixel(410, 205, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'hFF00FF) begin nErr++; $display("FAIL flash_cnt31 got %h want %h", gRgb, 24'hFF00FF); end
    repeat (31) frame();
    pixel(410, 205, 1, 4'd3, 4'd5);
    nCmp++; if (gRgb !== 24'h00FF00) begin nErr++; $display("FAIL flash_done got %h want %h", gRgb, 24'h00FF00); end
  endtask
`endif
  initial begin
    test_reset();
    test_sprite();
    test_priority();
    test_bullet();
    test_overlap();
    test_latch();
    test_async_reset();
`ifdef SPRITE_HIT_FLASH_EN
    test_flash();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
